apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum number of ACCESS cycles with PREADY low before the transfer is aborted (range 1-255).
REQ-002 PCLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 PRESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  SHALL be requester transfer requests, held high until the matching done.
REQ-005 addr0, addr1  input  9 each  SHALL be the request address: bit 8 selects the slave (0 = slave 1, 1 = slave 2), and bits 7:0 are the slave offset.
REQ-006 wdata0, wdata1  input  8 each; write0, write1  input  1 each  SHALL be the write data and direction (1 = write).
REQ-007 done0, done1  output  1 each  SHALL be one-cycle completion pulses per requester.
REQ-008 err  output  1  SHALL be a timeout flag, valid only with done0/done1.
REQ-009 rdata  output  8  SHALL be the read data, valid only with done of a read.
REQ-010 PSEL1, PSEL2, PENABLE, PWRITE  output  1 each; PADDR, PWDATA  output  8 each  SHALL drive the APB master signals.
REQ-011 PRDATA1, PRDATA2  input  8 each; PREADY1, PREADY2  input  1 each  SHALL be the per-slave APB responses.

Function
REQ-012 The FSM SHALL have three states, IDLE, SETUP and ACCESS, and all outputs SHALL be registered.
REQ-013 In IDLE with any req high, the block SHALL grant one requester, capture its addr/wdata/write into internal registers and go to SETUP.
REQ-014 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-015 In SETUP, the selected PSELx SHALL be 1, PENABLE 0, and PADDR/PWDATA/PWRITE driven from the captured values; the FSM SHALL always go to ACCESS on the next cycle.
REQ-016 In ACCESS, PENABLE SHALL be 1 and PSELx, PADDR, PWDATA and PWRITE SHALL be held stable.
REQ-017 In ACCESS, only the PREADY of the selected slave SHALL be sampled; the other slave's PREADY SHALL be ignored.
REQ-018 In ACCESS with selected PREADY=1, the block SHALL go to IDLE and, in the next cycle, pulse done of the granted requester with err=0.
REQ-019 On a read completion, rdata SHALL be the selected slave's PRDATA sampled at the completing edge.
REQ-020 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY low.
REQ-021 When the wait counter equals TIMEOUT with PREADY still low, the block SHALL abort to IDLE and pulse done and err together, with rdata=0.
REQ-022 Zero-wait latency SHALL be: req sampled at edge N, SETUP at N+1, ACCESS at N+2, done at N+3.
REQ-023 The minimum spacing between transfers SHALL be one IDLE cycle; there SHALL be no back-to-back SETUP.
REQ-024 A req still high in the IDLE cycle that carries its own done pulse SHALL be treated as a new request and arbitrated normally.
REQ-025 Changes on req/addr/wdata/write after capture SHALL NOT affect the transfer in flight.
REQ-026 A req deasserted mid-transfer SHALL be ignored, and the transfer SHALL complete.
REQ-027 In IDLE, both PSEL1 and PSEL2 SHALL be 0, PENABLE 0, and PADDR/PWDATA SHALL hold their last values.
REQ-028 At most one PSELx SHALL be high in any cycle.
REQ-029 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-030 PRESET high SHALL immediately force state IDLE and drive PSEL1, PSEL2, PENABLE, PWRITE, done0, done1 and err to 0.
REQ-031 PRESET high SHALL also clear PADDR, PWDATA, rdata, the wait counter and the round-robin pointer (next tie goes to requester 0).
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; after release, a pending req SHALL restart from IDLE.

Verification
REQ-033 The bench SHALL cover a zero-wait read: req0=1, addr0=0x105, PREADY2=1, PRDATA2=0xA5 -> PSEL2 for 2 cycles, done0 at N+3, rdata=0xA5, err=0.
REQ-034 The bench SHALL cover a two-wait write: req1=1, addr1=0x010, wdata1=0x3C, PREADY1 low for 2 ACCESS cycles -> PWDATA=0x3C stable for 4 cycles, done1 at N+5.
REQ-035 The bench SHALL cover a tie from reset: req0=req1=1 held high -> grants alternate 0,1,0,1 and done0/done1 never coincide.
REQ-036 The bench SHALL cover a timeout: TIMEOUT=15, selected PREADY held 0 -> abort after 15 ACCESS cycles, done+err pulse, rdata=0, PSEL deasserted.
REQ-037 The bench SHALL cover reset mid-ACCESS: PRESET pulsed while in ACCESS -> all outputs 0 asynchronously, no done, and the next tie is won by requester 0.
REQ-038 The bench SHALL cover wrong-slave ready: transfer to slave 1 with PREADY2=1 and PREADY1=0 -> the block stays in ACCESS until PREADY1=1.

Source files
------------

// File: rtl/apb_arb_master_if.sv
// Requester and APB bus signals of the two-requester APB master; master modport is the
// arbiter's view, slave modport is the view of whatever drives requests and slave responses.
interface apb_arb_master_if;
  logic       req0, req1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       write0, write1;
  logic       done0, done1, err;
  logic [7:0] rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  modport master (
    input  req0, req1, addr0, addr1, wdata0, wdata1, write0, write1,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2,
    output done0, done1, err, rdata,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req0, req1, addr0, addr1, wdata0, wdata1, write0, write1,
    output PRDATA1, PRDATA2, PREADY1, PREADY2,
    input  done0, done1, err, rdata,
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_arb_master.sv
// Round-robin arbiter for two requesters driving one APB master port to two slaves.
// Zero-wait transfer: SETUP, ACCESS, then done in the following IDLE cycle; slave waits stretch ACCESS up to TIMEOUT.
module apb_arb_master #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_arb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       prio_q, prio_d;
  logic [8:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       psel1_q, psel1_d, psel2_q, psel2_d;
  logic       penable_q, penable_d, pwrite_q, pwrite_d;
  logic       done0_q, done0_d, done1_q, done1_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d;

  logic       pready_sel;
  logic [7:0] prdata_sel;
  logic       complete, abort_xfer;

  // Only the addressed slave's response matters; the other slave is ignored.
  assign pready_sel = addr_q[8] ? bus.PREADY2 : bus.PREADY1;
  assign prdata_sel = addr_q[8] ? bus.PRDATA2 : bus.PRDATA1;
  assign cnt_inc    = cnt_q + 8'd1;
  assign complete   = (state_q == ACCESS) && pready_sel;
  assign abort_xfer = (state_q == ACCESS) && !pready_sel && (cnt_inc == TO_CNT);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // prio_q names the requester that wins a tie: the one not granted last.
          gnt_d   = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          prio_d  = ~gnt_d;
          addr_d  = gnt_d ? bus.addr1  : bus.addr0;
          wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
          write_d = gnt_d ? bus.write1 : bus.write0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!pready_sel) cnt_d = cnt_inc;
        if (complete || abort_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel1_d   = (state_d != IDLE) && !addr_d[8];
    psel2_d   = (state_d != IDLE) &&  addr_d[8];
    penable_d = (state_d == ACCESS);
    pwrite_d  = (state_d != IDLE) && write_d;
    done0_d   = (complete || abort_xfer) && !gnt_q;
    done1_d   = (complete || abort_xfer) &&  gnt_q;
    err_d     = abort_xfer;
    rdata_d   = rdata_q;
    if (abort_xfer) begin
      rdata_d = '0;
    end else if (complete && !write_q) begin
      rdata_d = prdata_sel;
    end
  end

  assign bus.PSEL1   = psel1_q;
  assign bus.PSEL2   = psel2_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = addr_q[7:0];
  assign bus.PWDATA  = wdata_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: inputs driven and outputs sampled on the falling edge.
module tb_apb_arb_master;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int   total = 0;
  int   bad = 0;

  apb_arb_master_if bus ();

  apb_arb_master #(.TIMEOUT(15)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic test_reset();
    @(negedge PCLK);
    @(negedge PCLK);
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0, bus.done1, bus.err} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0, bus.done1, bus.err});
    end
    total++;
    if ({bus.PADDR, bus.PWDATA, bus.rdata} !== 24'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=000000", {bus.PADDR, bus.PWDATA, bus.rdata});
    end
    PRESET = 1'b0;
  endtask

  task automatic test_zero_wait_read();
    @(negedge PCLK);
    bus.addr0 = 9'h105; bus.write0 = 1'b0; bus.wdata0 = 8'h00;
    bus.PREADY1 = 1'b0; bus.PREADY2 = 1'b1; bus.PRDATA2 = 8'hA5;
    bus.req0 = 1'b1;
    @(negedge PCLK);
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0} !== 5'b01000 || bus.PADDR !== 8'h05) begin
      bad++; $display("FAIL rd_setup got=%b addr=%h exp=01000 addr=05", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0}, bus.PADDR);
    end
    @(negedge PCLK);
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0} !== 5'b01100) begin
      bad++; $display("FAIL rd_access got=%b exp=01100", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0});
    end
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b100 || bus.rdata !== 8'hA5 || {bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b000) begin
      bad++; $display("FAIL rd_done got=%b rdata=%h psel=%b exp=100 rdata=a5 psel=000", {bus.done0, bus.done1, bus.err}, bus.rdata, {bus.PSEL1, bus.PSEL2, bus.PENABLE});
    end
    bus.req0 = 1'b0;
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.PSEL1, bus.PSEL2} !== 3'b000) begin
      bad++; $display("FAIL rd_after got=%b exp=000", {bus.done0, bus.PSEL1, bus.PSEL2});
    end
  endtask

  // Slave-1 write with two wait states while slave 2 shows ready the whole time.
  task automatic test_two_wait_write();
    logic [3:0] exp_pins;
    bus.addr1 = 9'h010; bus.wdata1 = 8'h3C; bus.write1 = 1'b1;
    bus.PREADY1 = 1'b0; bus.PREADY2 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (i == 0) begin
        bus.wdata1 = 8'hFF; bus.addr1 = 9'h1FF; bus.write1 = 1'b0;
      end
      exp_pins = (i == 0) ? 4'b1001 : 4'b1011;
      total++;
      if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE} !== exp_pins || bus.PWDATA !== 8'h3C || bus.PADDR !== 8'h10 || bus.done1 !== 1'b0) begin
        bad++; $display("FAIL wr_cycle%0d got=%b wdata=%h addr=%h done1=%b exp=%b wdata=3c addr=10 done1=0", i, {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE}, bus.PWDATA, bus.PADDR, bus.done1, exp_pins);
      end
      if (i == 3) bus.PREADY1 = 1'b1;
    end
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b010 || {bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b000 || bus.PWDATA !== 8'h3C) begin
      bad++; $display("FAIL wr_done got=%b psel=%b wdata=%h exp=010 psel=000 wdata=3c", {bus.done0, bus.done1, bus.err}, {bus.PSEL1, bus.PSEL2, bus.PENABLE}, bus.PWDATA);
    end
    bus.req1 = 1'b0;
  endtask

  task automatic test_rr_tie();
    int n = 0;
    int clash = 0;
    int both_sel = 0;
    int rd_bad = 0;
    logic [3:0] order = 4'b0;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.addr0 = 9'h101; bus.write0 = 1'b0;
    bus.addr1 = 9'h002; bus.write1 = 1'b0;
    bus.PRDATA1 = 8'h11; bus.PRDATA2 = 8'h22;
    bus.PREADY1 = 1'b1; bus.PREADY2 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge PCLK);
      if (bus.done0 && bus.done1) clash++;
      if (bus.PSEL1 && bus.PSEL2) both_sel++;
      if (bus.done0 || bus.done1) begin
        order[n] = bus.done1;
        if (bus.rdata !== (bus.done1 ? 8'h11 : 8'h22)) rd_bad++;
        n++;
        if (n == 4) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", n); end
    total++;
    if (order !== 4'b1010) begin bad++; $display("FAIL rr_order got=%b exp=1010", order); end
    total++;
    if (clash !== 0 || both_sel !== 0) begin bad++; $display("FAIL rr_exclusive done_clash=%0d psel_clash=%0d exp=0/0", clash, both_sel); end
    total++;
    if (rd_bad !== 0) begin bad++; $display("FAIL rr_rdata got=%0d_bad exp=0", rd_bad); end
  endtask

  // Also drops req0 right after capture: the transfer must still finish.
  task automatic test_timeout();
    int acc = 0;
    bit got = 0;
    bus.addr0 = 9'h1AB; bus.write0 = 1'b0;
    bus.PREADY2 = 1'b0; bus.PREADY1 = 1'b1;
    bus.req0 = 1'b1;
    @(negedge PCLK);
    bus.req0 = 1'b0;
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b010) begin
      bad++; $display("FAIL to_setup got=%b exp=010", {bus.PSEL1, bus.PSEL2, bus.PENABLE});
    end
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge PCLK);
      if (bus.done0 || bus.done1) got = 1;
      else if (bus.PENABLE && bus.PSEL2) acc++;
    end
    total++;
    if (!got) begin bad++; $display("FAIL to_no_done got=none exp=done0"); end
    total++;
    if (acc !== 15) begin bad++; $display("FAIL to_access_cycles got=%0d exp=15", acc); end
    total++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b101 || bus.rdata !== 8'h00) begin
      bad++; $display("FAIL to_done got=%b rdata=%h exp=101 rdata=00", {bus.done0, bus.done1, bus.err}, bus.rdata);
    end
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b000 || bus.PADDR !== 8'hAB) begin
      bad++; $display("FAIL to_idle got=%b addr=%h exp=000 addr=ab", {bus.PSEL1, bus.PSEL2, bus.PENABLE}, bus.PADDR);
    end
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.err, bus.PSEL2} !== 3'b000) begin
      bad++; $display("FAIL to_after got=%b exp=000", {bus.done0, bus.err, bus.PSEL2});
    end
  endtask

  task automatic test_reset_mid_access();
    bus.addr0 = 9'h033; bus.wdata0 = 8'h5A; bus.write0 = 1'b1;
    bus.addr1 = 9'h144; bus.wdata1 = 8'hC3; bus.write1 = 1'b0;
    bus.PREADY1 = 1'b0; bus.PREADY2 = 1'b0;
    bus.req0 = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    total++;
    if ({bus.PSEL1, bus.PENABLE} !== 2'b11) begin
      bad++; $display("FAIL rst_pre_access got=%b exp=11", {bus.PSEL1, bus.PENABLE});
    end
    #2 PRESET = 1'b1;
    #1;
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0, bus.done1, bus.err} !== 7'b0 || {bus.PADDR, bus.PWDATA, bus.rdata} !== 24'h0) begin
      bad++; $display("FAIL rst_async got=%b data=%h exp=0000000 data=000000", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.done0, bus.done1, bus.err}, {bus.PADDR, bus.PWDATA, bus.rdata});
    end
    bus.req1 = 1'b1;
    bus.PREADY1 = 1'b1; bus.PREADY2 = 1'b1;
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.done1} !== 2'b00) begin bad++; $display("FAIL rst_no_done got=%b exp=00", {bus.done0, bus.done1}); end
    PRESET = 1'b0;
    @(negedge PCLK);
    total++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE} !== 4'b1001 || bus.PADDR !== 8'h33 || bus.PWDATA !== 8'h5A) begin
      bad++; $display("FAIL rst_tie_grant got=%b addr=%h wdata=%h exp=1001 addr=33 wdata=5a", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    total++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b100) begin
      bad++; $display("FAIL rst_restart_done got=%b exp=100", {bus.done0, bus.done1, bus.err});
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.write0 = 1'b0; bus.write1 = 1'b0;
    bus.PRDATA1 = '0; bus.PRDATA2 = '0;
    bus.PREADY1 = 1'b0; bus.PREADY2 = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_two_wait_write();
    test_rr_tie();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
